// File: rtl/score_pkg.sv
// Shared defaults for the reaction-time score bank: result width, history depth,
// and the "no best yet" value.
package score_pkg;

    localparam int RESULT_W      = 13;
    localparam int HISTORY_DEPTH = 8;

    localparam logic [RESULT_W-1:0] BEST_INIT = {RESULT_W{1'b1}};

endpackage : score_pkg

// File: rtl/score_register_bank_if.sv
// Push/read bus between the reaction timer (master) and the score bank (slave).
// Push is fire-and-forget with no backpressure; reads are age-indexed.
interface score_register_bank_if #(
    parameter int WIDTH = score_pkg::RESULT_W,
    parameter int DEPTH = score_pkg::HISTORY_DEPTH
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = WIDTH + $clog2(DEPTH + 1);

    logic             Push;
    logic [WIDTH-1:0] PushData;
    logic [PTR_W-1:0] RdAddr;
    logic [WIDTH-1:0] RdData;
    logic [PTR_W:0]   Count;
    logic             Full;
    logic [SUM_W-1:0] Sum;
    logic [WIDTH-1:0] Best;
    logic             BestValid;

    modport master (
        output Push, PushData, RdAddr,
        input  RdData, Count, Full, Sum, Best, BestValid
    );

    modport slave (
        input  Push, PushData, RdAddr,
        output RdData, Count, Full, Sum, Best, BestValid
    );

endinterface : score_register_bank_if

// File: rtl/score_ring_mem.sv
// DEPTH x WIDTH result storage: one synchronous write port, two async read ports.
// Out-of-range read indices (non-power-of-2 DEPTH) return zero.
module score_ring_mem #(
    parameter int WIDTH = score_pkg::RESULT_W,
    parameter int DEPTH = score_pkg::HISTORY_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [PTR_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_dat,
    input  logic [PTR_W-1:0] ev_idx,
    output logic [WIDTH-1:0] ev_dat
);
    import score_pkg::*;

    localparam logic [PTR_W:0] DEPTH_X = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = ({1'b0, rd_idx} < DEPTH_X) ? mem[rd_idx] : '0;
    assign ev_dat = ({1'b0, ev_idx} < DEPTH_X) ? mem[ev_idx] : '0;

endmodule : score_ring_mem

// File: rtl/score_register_bank.sv
// Circular history of the last DEPTH results with count, running sum and all-time best.
// Reads have 1-cycle latency and see pre-push state; pushes are never stalled (oldest is overwritten).
module score_register_bank #(
    parameter int WIDTH = score_pkg::RESULT_W,
    parameter int DEPTH = score_pkg::HISTORY_DEPTH
) (
    input  logic                  Clock,
    input  logic                  CLR,
    score_register_bank_if.slave  bus
);
    import score_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = WIDTH + $clog2(DEPTH + 1);
    localparam int IDX_W = PTR_W + 2;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] DEPTH_X  = IDX_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [SUM_W-1:0] sum;
    logic [WIDTH-1:0] best;
    logic             best_valid;
    logic [WIDTH-1:0] rd_data;

    logic             full;
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [IDX_W-1:0] idx_raw;
    logic [IDX_W-1:0] idx_wrap;
    logic [PTR_W-1:0] rd_idx;
    logic             rd_hit;
    logic [WIDTH-1:0] mem_rd;
    logic [WIDTH-1:0] evict;
    logic [SUM_W-1:0] sum_next;
    logic             best_take;

    assign full  = (count == FULL_CNT);
    assign wr_en = bus.Push && !CLR;

    // Explicit compare rather than natural overflow so non-power-of-2 depths wrap correctly.
    assign wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);

    // Age -> physical index: (wr_ptr - 1 - RdAddr) mod DEPTH, biased by DEPTH to stay non-negative.
    // Only meaningful when rd_hit, which guarantees RdAddr < DEPTH so one correction suffices.
    always_comb begin
        idx_raw  = {2'b00, wr_ptr} + DEPTH_X - IDX_W'(1) - {2'b00, bus.RdAddr};
        idx_wrap = idx_raw;
        if (idx_raw >= DEPTH_X) begin
            idx_wrap = idx_raw - DEPTH_X;
        end
        rd_idx = idx_wrap[PTR_W-1:0];
    end

    assign rd_hit = ({1'b0, bus.RdAddr} < count);

    // When full the slot under wr_ptr is the oldest entry and is about to be overwritten.
    always_comb begin
        sum_next = sum + SUM_W'(bus.PushData);
        if (full) begin
            sum_next = sum_next - SUM_W'(evict);
        end
    end

    assign best_take = !best_valid || (bus.PushData < best);

    score_ring_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk    (Clock),
        .wr_en  (wr_en),
        .wr_idx (wr_ptr),
        .wr_dat (bus.PushData),
        .rd_idx (rd_idx),
        .rd_dat (mem_rd),
        .ev_idx (wr_ptr),
        .ev_dat (evict)
    );

    always_ff @(posedge Clock) begin
        if (CLR) begin
            wr_ptr     <= '0;
            count      <= '0;
            sum        <= '0;
            best       <= {WIDTH{1'b1}};
            best_valid <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_data <= rd_hit ? mem_rd : '0;
            if (bus.Push) begin
                wr_ptr     <= wr_ptr_next;
                sum        <= sum_next;
                best_valid <= 1'b1;
                if (!full) begin
                    count <= count + (PTR_W + 1)'(1);
                end
                if (best_take) begin
                    best <= bus.PushData;
                end
            end
        end
    end

    assign bus.RdData    = rd_data;
    assign bus.Count     = count;
    assign bus.Full      = full;
    assign bus.Sum       = sum;
    assign bus.Best      = best;
    assign bus.BestValid = best_valid;

endmodule : score_register_bank
